// File: rtl/pss_peak_detector_if.sv
// pss_peak_detector_if: unsigned magnitude stream from the PSS correlator (no backpressure).
interface pss_peak_detector_if #(
    parameter int IN_DW = 32
);
    logic [IN_DW-1:0] tdata;
    logic             tvalid;
    modport master (output tdata, tvalid);
    modport slave  (input tdata, tvalid);
endinterface

// File: rtl/pss_peak_detector.sv
// pss_peak_detector: reports each above-threshold local maximum once it has
// held for WINDOW_LEN following samples, with its sample index and value.
module pss_peak_detector #(
    parameter int IN_DW      = 32,
    parameter int CNT_DW     = 16,
    parameter int WINDOW_LEN = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    pss_peak_detector_if.slave        s_axis_in,
    input  logic [IN_DW-1:0]          threshold_i,
    output logic                      peak_detected_o,
    output logic [IN_DW-1:0]          peak_value_o,
    output logic [CNT_DW-1:0]         peak_idx_o,
    output logic                      busy_o
);
    typedef enum logic {IDLE, TRACK} state_t;
    state_t            state, state_nxt;
    logic [IN_DW-1:0]  cand_value;
    logic [CNT_DW-1:0] cand_idx, idx, win_cnt;
    logic              load, win_inc, fire;
    assign busy_o = state == TRACK;
    // Ties never replace the candidate, so the earliest of equal samples wins.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        win_inc   = 1'b0;
        fire      = 1'b0;
        if (s_axis_in.tvalid) begin
            if (state == IDLE) begin
                load      = s_axis_in.tdata > threshold_i;
                state_nxt = load ? TRACK : IDLE;
            end else if (s_axis_in.tdata > cand_value) begin
                load = 1'b1;
            end else if (win_cnt == CNT_DW'(WINDOW_LEN - 1)) begin
                fire      = 1'b1;
                state_nxt = IDLE;
            end else begin
                win_inc = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            idx             <= '0;
            win_cnt         <= '0;
            cand_value      <= '0;
            cand_idx        <= '0;
            peak_detected_o <= 1'b0;
            peak_value_o    <= '0;
            peak_idx_o      <= '0;
        end else begin
            state           <= state_nxt;
            peak_detected_o <= fire;
            if (s_axis_in.tvalid)
                idx <= idx + 1'b1;
            if (load) begin
                cand_value <= s_axis_in.tdata;
                cand_idx   <= idx;
                win_cnt    <= '0;
            end else if (win_inc) begin
                win_cnt <= win_cnt + 1'b1;
            end
            if (fire) begin
                peak_value_o <= cand_value;
                peak_idx_o   <= cand_idx;
            end
        end
    end
endmodule

// File: doc/pss_peak_detector.md
# pss_peak_detector

Downstream stage of the PSS correlator. Consumes the correlator's unsigned magnitude-squared stream, one value per valid sample. Finds local maxima that exceed a programmable threshold and reports each one once, after it has stayed the maximum for a fixed window of following samples. Detections carry the peak's sample index and value, and feed timing acquisition (SSB start / N_id_2 decision logic).

## Interface

Parameters:
- IN_DW, 32, width of the input magnitude (equal to the correlator's OUT_DW)
- CNT_DW, 16, width of the sample index counter
- WINDOW_LEN, 64, number of valid samples after a candidate with no larger value before the candidate is confirmed; legal range 1..2^CNT_DW-1

Ports (one clock; reset is synchronous and active-high):
- clk_i, input, 1, clock
- reset_i, input, 1, synchronous active-high reset
- s_axis_in_tdata, input, IN_DW, unsigned correlator magnitude
- s_axis_in_tvalid, input, 1, sample valid; no backpressure, always accepted
- threshold_i, input, IN_DW, unsigned detection threshold
- peak_detected_o, output, 1, one-cycle pulse per confirmed peak
- peak_value_o, output, IN_DW, magnitude of the last confirmed peak
- peak_idx_o, output, CNT_DW, sample index of the last confirmed peak
- busy_o, output, 1, high while a candidate is being tracked

## Operation

- Sample index counter: increments once per accepted sample (tvalid high) and wraps modulo 2^CNT_DW. The first sample after reset has index 0. Cycles with tvalid low change no state.
- Comparisons are unsigned.
- The FSM has two states, IDLE and TRACK.
- IDLE, on an accepted sample with tdata > threshold_i (strict):
  - load cand_value = tdata and cand_idx = current index
  - clear the window counter
  - go to TRACK
- IDLE, on any other accepted sample: stay in IDLE.
- TRACK, on an accepted sample with tdata > cand_value (strict): replace the candidate and clear the window counter.
- TRACK, on an accepted sample with tdata <= cand_value:
  - increment the window counter
  - if this is the WINDOW_LEN-th such consecutive sample, register peak_value_o = cand_value and peak_idx_o = cand_idx, pulse peak_detected_o, and return to IDLE
- Equal values never replace the candidate, so the earliest sample wins a tie.
- threshold_i is only consulted in IDLE. Changes during TRACK have no effect on the current candidate.
- The confirming sample is not re-evaluated against threshold_i. The earliest sample that can start a new candidate is the next accepted sample.
- busy_o = (state == TRACK).
- peak_value_o and peak_idx_o hold their values until the next detection.

## Timing

- All outputs are registered. Reset values: peak_detected_o=0, peak_value_o=0, peak_idx_o=0, busy_o=0. The FSM resets to IDLE, and the index and window counters reset to 0.
- Latency: with the peak accepted at edge t and continuous tvalid, the confirming sample is accepted at edge t+WINDOW_LEN. peak_detected_o is high for exactly the cycle following that edge. peak_value_o and peak_idx_o update on the same edge.
- With tvalid gaps, latency in cycles stretches, but it is always exactly WINDOW_LEN accepted samples after the final candidate.
- busy_o rises on the edge that accepts the first candidate. It falls on the edge that accepts the confirming sample.
- Reset asserted in TRACK discards the candidate with no pulse. A pulse due on the reset edge is suppressed.
- Index wrap: index 2^CNT_DW-1 is followed by 0. A candidate spanning the wrap reports its original index.
- Back-to-back peaks: a new candidate may start on the accepted sample immediately after the confirming one. Consecutive pulses are therefore separated by at least WINDOW_LEN+1 cycles.

## Test plan

The bench runs with WINDOW_LEN=8 and threshold_i=100 unless stated otherwise.

1. All samples 0 except index 10 = 500, continuous valid -> one pulse, in the cycle after index 18 is accepted; peak_value_o=500, peak_idx_o=10; busy_o high from index 10 through 18.
2. Index 10 = 500 and index 13 = 800, rest 0 -> single pulse after index 21, value 800, idx 13. No pulse for index 10.
3. Index 10 = 500 and index 12 = 500 (tie) -> single pulse after index 18, value 500, idx 10.
4. Same stimulus as scenario 1, with tvalid low on every other cycle -> pulse after the 19th accepted sample (index 18), value 500, idx 10. The pulse arrives about twice as many cycles later.
5. Scenario 1 stimulus with reset_i asserted for 1 cycle when index 14 would be accepted -> no pulse, all outputs 0. The next accepted sample has index 0. A peak of 300 at new index 5 is then reported with idx 5.
6. CNT_DW=4, peak of 200 at index 14, rest 0 -> the index wraps 15, 0, 1, …, 6. The pulse follows the sample with wrapped index 6, with peak_idx_o=14. Samples at exactly 100 (equal to threshold) never start a candidate.
